// File: rtl/fpu_issue_queue_if.sv
// fpu_issue_queue_if
// Groups the issue queue's dispatch, CDB, flush, FPU issue and occupancy
// signals. The clock and reset are not part of this bundle.
//   master : the environment side. It drives dispatch, the CDB and flush, and
//            it observes the issue outputs.
//   slave  : the issue queue itself.
// DEPTH sets the width of count. It must match the DEPTH of the attached
// queue.
interface fpu_issue_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  // dispatch
  logic          disp_valid;
  logic          disp_ready;
  logic [4:0]    disp_funct5;
  logic [2:0]    disp_rob_idx;
  logic          disp_src1_rdy;
  logic          disp_src2_rdy;
  logic [31:0]   disp_src1_val;
  logic [31:0]   disp_src2_val;
  logic [2:0]    disp_src1_tag;
  logic [2:0]    disp_src2_tag;
  // common data bus
  logic          cdb_valid;
  logic [2:0]    cdb_rob_idx;
  logic [31:0]   cdb_data;
  // FPU issue
  logic          fpu_start;
  logic [4:0]    funct5;
  logic [31:0]   operand1;
  logic [31:0]   operand2;
  logic [2:0]    EXE_rob_idx;
  logic [CW-1:0] count;

  modport master (
    output flush, disp_valid, disp_funct5, disp_rob_idx,
           disp_src1_rdy, disp_src2_rdy, disp_src1_val, disp_src2_val,
           disp_src1_tag, disp_src2_tag, cdb_valid, cdb_rob_idx, cdb_data,
    input  disp_ready, fpu_start, funct5, operand1, operand2, EXE_rob_idx, count
  );

  modport slave (
    input  flush, disp_valid, disp_funct5, disp_rob_idx,
           disp_src1_rdy, disp_src2_rdy, disp_src1_val, disp_src2_val,
           disp_src1_tag, disp_src2_tag, cdb_valid, cdb_rob_idx, cdb_data,
    output disp_ready, fpu_start, funct5, operand1, operand2, EXE_rob_idx, count
  );
endinterface

// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue
// Compacting issue queue in front of the pipelined FADD.S/FSUB.S unit.
// Renamed ops wait here until both source operands are valid. Missing operands
// are captured from the CDB. The oldest ready op issues, at most one per cycle.
// Ports:
//   clk : clock
//   rst : synchronous, active-high reset
//   bus : fpu_issue_queue_if.slave, which carries dispatch in, CDB in, flush
//         in, the registered FPU issue outputs and the occupancy count.
module fpu_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  fpu_issue_queue_if.slave bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic        valid;
    logic [4:0]  funct5;
    logic [2:0]  rob_idx;
    logic        src1_rdy;
    logic [2:0]  src1_tag;
    logic [31:0] src1_val;
    logic        src2_rdy;
    logic [2:0]  src2_tag;
    logic [31:0] src2_val;
  } entry_t;

  // Entry 0 is always the oldest. Valid entries occupy indices 0..count-1.
  entry_t        q     [DEPTH];
  entry_t        q_wk  [DEPTH];  // stored entries after this cycle's CDB capture
  entry_t        q_nxt [DEPTH];  // after removal, compaction and write
  entry_t        new_entry;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] wr_idx;
  logic          disp_fire;
  logic          sel_found;
  logic [IW-1:0] sel_idx;

  logic          fpu_start_q;
  logic [4:0]    funct5_q;
  logic [31:0]   operand1_q;
  logic [31:0]   operand2_q;
  logic [2:0]    exe_rob_idx_q;

  // Captures a CDB result into any waiting source of an entry. This serves
  // both for stored entries and for the bypass of an op being dispatched.
  function automatic entry_t wake(entry_t e, logic cv, logic [2:0] ct,
                                  logic [31:0] cd);
    entry_t r;
    r = e;
    if (e.valid && cv && !e.src1_rdy && (e.src1_tag == ct)) begin
      r.src1_rdy = 1'b1;
      r.src1_val = cd;
    end
    if (e.valid && cv && !e.src2_rdy && (e.src2_tag == ct)) begin
      r.src2_rdy = 1'b1;
      r.src2_val = cd;
    end
    return r;
  endfunction

  // A full queue refuses dispatch even when it issues in the same cycle.
  assign bus.disp_ready = (count_q < CW'(DEPTH));
  assign disp_fire      = bus.disp_valid && bus.disp_ready;

  // Select the oldest entry whose registered rdy bits are both set. A wakeup
  // therefore becomes visible to select one cycle after the broadcast.
  always_comb begin
    // NOTE: every signal written here gets a default first, so that no path
    // leaves it unassigned and no latch is inferred.
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (q[i].valid && q[i].src1_rdy && q[i].src2_rdy) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    new_entry          = '0;
    new_entry.valid    = 1'b1;
    new_entry.funct5   = bus.disp_funct5;
    new_entry.rob_idx  = bus.disp_rob_idx;
    new_entry.src1_rdy = bus.disp_src1_rdy;
    new_entry.src1_tag = bus.disp_src1_tag;
    new_entry.src1_val = bus.disp_src1_val;
    new_entry.src2_rdy = bus.disp_src2_rdy;
    new_entry.src2_tag = bus.disp_src2_tag;
    new_entry.src2_val = bus.disp_src2_val;
    new_entry          = wake(new_entry, bus.cdb_valid, bus.cdb_rob_idx, bus.cdb_data);

    for (int i = 0; i < DEPTH; i++) begin
      q_wk[i] = wake(q[i], bus.cdb_valid, bus.cdb_rob_idx, bus.cdb_data);
    end

    // Entries above the issued one shift down by one, so age order is kept.
    for (int i = 0; i < DEPTH - 1; i++) begin
      q_nxt[i] = (sel_found && (IW'(i) >= sel_idx)) ? q_wk[i+1] : q_wk[i];
    end
    q_nxt[DEPTH-1] = sel_found ? '0 : q_wk[DEPTH-1];

    // The first free slot after compaction. disp_fire implies count < DEPTH,
    // so wr_idx always fits in an entry index.
    wr_idx = count_q - CW'(sel_found);
    if (disp_fire) begin
      q_nxt[wr_idx[IW-1:0]] = new_entry;
    end

    count_nxt = count_q + CW'(disp_fire) - CW'(sel_found);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only the valid bits of the entry storage are reset. The payload
      // is ignored while valid is low, so it needs no reset of its own.
      for (int i = 0; i < DEPTH; i++) begin
        q[i].valid <= 1'b0;
      end
      count_q       <= '0;
      fpu_start_q   <= 1'b0;
      funct5_q      <= '0;
      operand1_q    <= '0;
      operand2_q    <= '0;
      exe_rob_idx_q <= '0;
    end else if (bus.flush) begin
      // A squash drops every entry and any issue of this cycle. The data
      // outputs keep their last values.
      for (int i = 0; i < DEPTH; i++) begin
        q[i].valid <= 1'b0;
      end
      count_q     <= '0;
      fpu_start_q <= 1'b0;
    end else begin
      q           <= q_nxt;
      count_q     <= count_nxt;
      fpu_start_q <= sel_found;
      if (sel_found) begin
        funct5_q      <= q[sel_idx].funct5;
        operand1_q    <= q[sel_idx].src1_val;
        operand2_q    <= q[sel_idx].src2_val;
        exe_rob_idx_q <= q[sel_idx].rob_idx;
      end
    end
  end

  assign bus.fpu_start   = fpu_start_q;
  assign bus.funct5      = funct5_q;
  assign bus.operand1    = operand1_q;
  assign bus.operand2    = operand2_q;
  assign bus.EXE_rob_idx = exe_rob_idx_q;
  assign bus.count       = count_q;
endmodule

// File: tb/tb_fpu_issue_queue.sv
// tb_fpu_issue_queue
// Scoreboard bench for fpu_issue_queue. The reference model keeps the waiting
// ops as an age-ordered queue. At each clock edge it issues the first op whose
// operands are both known, captures CDB results and appends accepted
// dispatches. Each issue is pushed to a scoreboard. A negedge monitor pops the
// scoreboard and compares it against the DUT outputs, together with count and
// disp_ready.
module tb_fpu_issue_queue;
  localparam int DEPTH = 4;
  localparam logic [4:0] F_ADD = 5'b00000;
  localparam logic [4:0] F_SUB = 5'b00001;

  logic clk = 1'b0;
  logic rst;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  fpu_issue_queue_if #(.DEPTH(DEPTH)) bus ();

  fpu_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [4:0]  f5;
    logic [2:0]  rob;
    logic        r1;
    logic [2:0]  t1;
    logic [31:0] v1;
    logic        r2;
    logic [2:0]  t2;
    logic [31:0] v2;
  } op_t;

  typedef struct packed {
    logic [4:0]  f5;
    logic [2:0]  rob;
    logic [31:0] a;
    logic [31:0] b;
  } iss_t;

  op_t  model_q [$];
  iss_t sb [$];
  iss_t last;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // An operand becomes known when a broadcast carries the tag it waits on.
  function automatic op_t resolve(op_t o, logic cv, logic [2:0] ct, logic [31:0] cd);
    op_t r;
    r = o;
    if (cv && !o.r1 && o.t1 == ct) begin r.r1 = 1'b1; r.v1 = cd; end
    if (cv && !o.r2 && o.t2 == ct) begin r.r2 = 1'b1; r.v2 = cd; end
    return r;
  endfunction

  // Reference model, stepped at every clock edge.
  always @(posedge clk) begin : model
    int   n;
    int   hit;
    op_t  op;
    if (rst) begin
      model_q.delete();
      sb.delete();
      last = '0;
    end else if (bus.flush) begin
      model_q.delete();
    end else begin
      n   = model_q.size();
      hit = -1;
      foreach (model_q[i]) begin
        if (hit < 0 && model_q[i].r1 && model_q[i].r2) hit = i;
      end
      if (hit >= 0) begin
        sb.push_back({model_q[hit].f5, model_q[hit].rob, model_q[hit].v1, model_q[hit].v2});
        model_q.delete(hit);
      end
      foreach (model_q[i]) begin
        model_q[i] = resolve(model_q[i], bus.cdb_valid, bus.cdb_rob_idx, bus.cdb_data);
      end
      if (bus.disp_valid && n < DEPTH) begin
        op = {bus.disp_funct5, bus.disp_rob_idx,
              bus.disp_src1_rdy, bus.disp_src1_tag, bus.disp_src1_val,
              bus.disp_src2_rdy, bus.disp_src2_tag, bus.disp_src2_val};
        model_q.push_back(resolve(op, bus.cdb_valid, bus.cdb_rob_idx, bus.cdb_data));
      end
    end
  end

  // Monitor: compares the DUT outputs with the scoreboard away from the edge.
  always @(negedge clk) begin : monitor
    iss_t e;
    if (mon_en) begin
      check("count", 32'(bus.count), 32'(model_q.size()));
      check("disp_ready", 32'(bus.disp_ready), 32'(model_q.size() < DEPTH));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("issue_start", 32'(bus.fpu_start), 32'd1);
        check("issue_funct5", 32'(bus.funct5), 32'(e.f5));
        check("issue_rob", 32'(bus.EXE_rob_idx), 32'(e.rob));
        check("issue_op1", bus.operand1, e.a);
        check("issue_op2", bus.operand2, e.b);
        last = e;
      end else begin
        check("idle_start", 32'(bus.fpu_start), 32'd0);
        check("hold_funct5", 32'(bus.funct5), 32'(last.f5));
        check("hold_rob", 32'(bus.EXE_rob_idx), 32'(last.rob));
        check("hold_op1", bus.operand1, last.a);
        check("hold_op2", bus.operand2, last.b);
      end
    end
  end

  task automatic clear_pulses();
    bus.disp_valid = 1'b0;
    bus.cdb_valid  = 1'b0;
    bus.flush      = 1'b0;
  endtask

  // Lets one clock edge consume the inputs set up so far, then drops the pulses.
  task automatic tick();
    @(negedge clk);
    clear_pulses();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_disp(input logic [4:0] f5, input logic [2:0] rob,
                          input logic r1, input logic [2:0] t1, input logic [31:0] v1,
                          input logic r2, input logic [2:0] t2, input logic [31:0] v2);
    bus.disp_valid    = 1'b1;
    bus.disp_funct5   = f5;
    bus.disp_rob_idx  = rob;
    bus.disp_src1_rdy = r1;
    bus.disp_src1_tag = t1;
    bus.disp_src1_val = v1;
    bus.disp_src2_rdy = r2;
    bus.disp_src2_tag = t2;
    bus.disp_src2_val = v2;
  endtask

  task automatic set_cdb(input logic [2:0] tag, input logic [31:0] data);
    bus.cdb_valid   = 1'b1;
    bus.cdb_rob_idx = tag;
    bus.cdb_data    = data;
  endtask

  initial begin
    rst = 1'b1;
    clear_pulses();
    set_disp(F_ADD, 3'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    bus.disp_valid = 1'b0;
    set_cdb(3'd0, 32'd0);
    bus.cdb_valid = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    rst    = 1'b0;

    check("reset_fpu_start", 32'(bus.fpu_start), 32'd0);
    check("reset_count", 32'(bus.count), 32'd0);
    check("reset_disp_ready", 32'(bus.disp_ready), 32'd1);
    check("reset_operand1", bus.operand1, 32'd0);
    check("reset_rob", 32'(bus.EXE_rob_idx), 32'd0);

    // A fully ready FADD issues two cycles after dispatch.
    set_disp(F_ADD, 3'd2, 1'b1, 3'd0, 32'h3F80_0000, 1'b1, 3'd0, 32'h4000_0000);
    tick();
    check("lat_c1_count", 32'(bus.count), 32'd1);
    check("lat_c1_start", 32'(bus.fpu_start), 32'd0);
    tick();
    check("lat_c2_start", 32'(bus.fpu_start), 32'd1);
    check("lat_c2_rob", 32'(bus.EXE_rob_idx), 32'd2);
    check("lat_c2_op1", bus.operand1, 32'h3F80_0000);
    check("lat_c2_op2", bus.operand2, 32'h4000_0000);
    tick();
    check("lat_c3_start", 32'(bus.fpu_start), 32'd0);
    check("lat_c3_count", 32'(bus.count), 32'd0);

    // A younger ready op overtakes a waiting one. The waiting op wakes on tag 5.
    set_disp(F_SUB, 3'd1, 1'b1, 3'd0, 32'h4080_0000, 1'b0, 3'd5, 32'd0);
    tick();
    set_disp(F_ADD, 3'd3, 1'b1, 3'd0, 32'h3F00_0000, 1'b1, 3'd0, 32'h3E80_0000);
    tick();
    idle(2);
    set_cdb(3'd5, 32'h4040_0000);
    tick();
    idle(3);

    // Dispatch bypass: the waiting source matches the CDB in the same cycle.
    set_disp(F_ADD, 3'd6, 1'b0, 3'd4, 32'd0, 1'b1, 3'd0, 32'h4120_0000);
    set_cdb(3'd4, 32'h4110_0000);
    tick();
    idle(3);

    // Full queue. Entry 2 wakes first, then 0, 1 and 3 wake together.
    set_disp(F_ADD, 3'd0, 1'b0, 3'd6, 32'd0, 1'b1, 3'd0, 32'h1111_0000);
    tick();
    set_disp(F_SUB, 3'd1, 1'b0, 3'd6, 32'd0, 1'b1, 3'd0, 32'h2222_0000);
    tick();
    set_disp(F_ADD, 3'd2, 1'b0, 3'd3, 32'd0, 1'b1, 3'd0, 32'h3333_0000);
    tick();
    set_disp(F_SUB, 3'd3, 1'b0, 3'd6, 32'd0, 1'b1, 3'd0, 32'h4444_0000);
    tick();
    check("full_count", 32'(bus.count), 32'd4);
    check("full_disp_ready", 32'(bus.disp_ready), 32'd0);
    set_cdb(3'd3, 32'hAAAA_0003);
    tick();
    idle(2);
    set_cdb(3'd6, 32'hAAAA_0006);
    tick();
    idle(5);

    // Dispatch and issue coincide with count = 2.
    set_disp(F_ADD, 3'd4, 1'b0, 3'd7, 32'd0, 1'b1, 3'd0, 32'h5555_0000);
    tick();
    set_disp(F_SUB, 3'd5, 1'b1, 3'd0, 32'h6666_0000, 1'b1, 3'd0, 32'h7777_0000);
    tick();
    set_disp(F_ADD, 3'd7, 1'b0, 3'd7, 32'd0, 1'b1, 3'd0, 32'h8888_0000);
    tick();
    check("same_cycle_count", 32'(bus.count), 32'd2);
    set_cdb(3'd7, 32'hBBBB_0007);
    tick();
    idle(4);

    // Flush while three ops wait and a fourth is being selected.
    set_disp(F_ADD, 3'd1, 1'b0, 3'd5, 32'd0, 1'b1, 3'd0, 32'h0101_0101);
    tick();
    set_disp(F_ADD, 3'd2, 1'b0, 3'd5, 32'd0, 1'b1, 3'd0, 32'h0202_0202);
    tick();
    set_disp(F_ADD, 3'd3, 1'b0, 3'd5, 32'd0, 1'b1, 3'd0, 32'h0303_0303);
    tick();
    set_disp(F_SUB, 3'd4, 1'b1, 3'd0, 32'h0404_0404, 1'b1, 3'd0, 32'h0505_0505);
    tick();
    bus.flush = 1'b1;
    tick();
    check("flush_start", 32'(bus.fpu_start), 32'd0);
    check("flush_count", 32'(bus.count), 32'd0);
    check("flush_disp_ready", 32'(bus.disp_ready), 32'd1);
    set_cdb(3'd5, 32'hDEAD_BEEF);
    tick();
    idle(3);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      bus.flush = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 60)
        set_disp(($urandom_range(0, 1) != 0) ? F_SUB : F_ADD, 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom());
      if ($urandom_range(0, 99) < 40)
        set_cdb(3'($urandom_range(0, 7)), $urandom());
      tick();
    end

    // Drain: broadcast every tag so no op is left waiting.
    for (int t = 0; t < 8; t++) begin
      set_cdb(3'(t), 32'h0C0C_0000 + 32'(t));
      tick();
    end
    idle(DEPTH + 4);
    check("drain_count", 32'(bus.count), 32'd0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
